uart_tx_sequencer: RTL

Drains the Tx FIFO into the UART Tx module one character at a time, sitting between the Tx FIFO, the Tx module and the register controller. For each character it pops the FIFO, presents the data and holds start until the Tx module signals done. It then inserts a programmable inter-frame gap. A watchdog, a flush mode and a transmitted-character counter are included. Its status outputs feed the status register.

---
 rtl/uart_tx_sequencer_pkg.sv | 20 ++
 rtl/uart_dn_cnt.sv | 36 +++
 rtl/uart_tx_sequencer.sv | 144 ++++++++++++++
 3 files changed

// File: rtl/uart_tx_sequencer_pkg.sv
// Shared definitions for the UART Tx sequencer: FSM state encodings and
// default field widths, also used by the register controller.
package uart_tx_sequencer_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_FLUSH = 3'd1,
    ST_POP   = 3'd2,
    ST_LOAD  = 3'd3,
    ST_START = 3'd4,
    ST_WAIT  = 3'd5,
    ST_GAP   = 3'd6
  } seq_state_e;

  localparam int unsigned DEF_DATA_W    = 8;
  localparam int unsigned DEF_GAP_W     = 8;
  localparam int unsigned DEF_TIMEOUT_W = 16;
  localparam int unsigned DEF_CNT_W     = 16;

endpackage

// File: rtl/uart_dn_cnt.sv
// Loadable down-counter with zero and last (count==1) flags.
// Load wins over decrement; decrement saturates at zero.
module uart_dn_cnt #(
  parameter int unsigned W = 8
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         load_i,
  input  logic [W-1:0] load_val_i,
  input  logic         dec_i,
  output logic         zero_o,
  output logic         last_o
);

  logic [W-1:0] cnt_q, cnt_d;

  // next count: load, else saturating decrement
  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = load_val_i;
    end else if (dec_i && (cnt_q != '0)) begin
      cnt_d = cnt_q - W'(1);
    end
  end

  // count register
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

  assign zero_o = (cnt_q == '0);
  assign last_o = (cnt_q == W'(1));

endmodule

// File: rtl/uart_tx_sequencer.sv
// Drains the Tx FIFO into the UART Tx module one character per frame,
// with a programmable inter-frame gap, a Tx-done watchdog, flush mode
// and a wrapping transmitted-character counter.
module uart_tx_sequencer
  import uart_tx_sequencer_pkg::*;
#(
  parameter int unsigned MAX_UART_DATA_W = DEF_DATA_W,
  parameter int unsigned GAP_W           = DEF_GAP_W,
  parameter int unsigned TIMEOUT_W       = DEF_TIMEOUT_W,
  parameter int unsigned CNT_W           = DEF_CNT_W
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic                       en_i,
  input  logic                       flush_i,
  input  logic [GAP_W-1:0]           gap_cycles_i,
  input  logic [TIMEOUT_W-1:0]       timeout_cycles_i,
  input  logic                       err_clr_i,
  input  logic                       tx_fifo_empty_i,
  input  logic [MAX_UART_DATA_W-1:0] tx_fifo_data_i,
  output logic                       tx_fifo_pop_o,
  input  logic                       tx_busy_i,
  input  logic                       tx_done_i,
  output logic                       tx_start_o,
  output logic [MAX_UART_DATA_W-1:0] tx_data_o,
  output logic                       seq_busy_o,
  output logic                       timeout_err_o,
  output logic [CNT_W-1:0]           tx_count_o
);

  seq_state_e                 state_q, state_d;
  logic                       tx_start_q, tx_start_d;
  logic [MAX_UART_DATA_W-1:0] tx_data_q, tx_data_d;
  logic                       err_q, err_d;
  logic [CNT_W-1:0]           tx_count_q, tx_count_d;

  logic gap_zero, gap_last;
  logic wd_zero, wd_last;
  logic in_wait;

  assign in_wait = (state_q == ST_WAIT);

  // Gap counter: loaded when a frame completes, counts down through GAP.
  uart_dn_cnt #(.W(GAP_W)) u_gap_cnt (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .load_i     (in_wait && tx_done_i),
    .load_val_i (gap_cycles_i),
    .dec_i      (state_q == ST_GAP),
    .zero_o     (gap_zero),
    .last_o     (gap_last)
  );

  // Watchdog: loaded in START; a zero load never reaches "last", so it
  // stays disarmed for the whole frame.
  uart_dn_cnt #(.W(TIMEOUT_W)) u_wd_cnt (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .load_i     (state_q == ST_START),
    .load_val_i (timeout_cycles_i),
    .dec_i      (in_wait && !wd_zero),
    .zero_o     (wd_zero),
    .last_o     (wd_last)
  );

  // Next-state and registered-output logic
  always_comb begin
    state_d    = state_q;
    tx_start_d = tx_start_q;
    tx_data_d  = tx_data_q;
    tx_count_d = tx_count_q;
    err_d      = err_q;
    if (err_clr_i) err_d = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (flush_i && !tx_fifo_empty_i) begin
          state_d = ST_FLUSH;
        end else if (en_i && !tx_fifo_empty_i && !tx_busy_i && !err_q) begin
          state_d = ST_POP;
        end
      end
      ST_FLUSH: begin
        if (tx_fifo_empty_i || !flush_i) state_d = ST_IDLE;
      end
      ST_POP: begin
        state_d = ST_LOAD;
      end
      ST_LOAD: begin
        tx_data_d = tx_fifo_data_i;
        state_d   = ST_START;
      end
      ST_START: begin
        tx_start_d = 1'b1;
        state_d    = ST_WAIT;
      end
      ST_WAIT: begin
        // done takes precedence over a watchdog expiry in the same cycle
        if (tx_done_i) begin
          tx_start_d = 1'b0;
          tx_count_d = tx_count_q + CNT_W'(1);
          state_d    = (gap_cycles_i != '0) ? ST_GAP : ST_IDLE;
        end else if (wd_last) begin
          tx_start_d = 1'b0;
          err_d      = 1'b1;
          state_d    = ST_IDLE;
        end
      end
      ST_GAP: begin
        if (gap_last || gap_zero) state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and output registers
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q    <= ST_IDLE;
      tx_start_q <= 1'b0;
      tx_data_q  <= '0;
      err_q      <= 1'b0;
      tx_count_q <= '0;
    end else begin
      state_q    <= state_d;
      tx_start_q <= tx_start_d;
      tx_data_q  <= tx_data_d;
      err_q      <= err_d;
      tx_count_q <= tx_count_d;
    end
  end

  // Flush pops every cycle the FIFO has data; transmit pops once in POP.
  assign tx_fifo_pop_o = (state_q == ST_POP) ||
                         ((state_q == ST_FLUSH) && !tx_fifo_empty_i);
  assign tx_start_o    = tx_start_q;
  assign tx_data_o     = tx_data_q;
  assign seq_busy_o    = (state_q != ST_IDLE);
  assign timeout_err_o = err_q;
  assign tx_count_o    = tx_count_q;

endmodule
